// File: rtl/topgun_pkg.sv
// Shared constants and types for the topgun sprite pixel pipeline.
// Sprite geometry, ROM address width and the sprite ROM address formula.
package topgun_pkg;

  localparam int SPRITE_W        = 64;
  localparam int SPRITE_H        = 48;
  localparam int NUM_FRAMES      = 2;
  localparam int ANIM_DIV        = 8;
  localparam int TRANSPARENT_IDX = 0;
  localparam int ADDR_W          = 13;

  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int DIV_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef logic [9:0]        coord_t;
  typedef logic [ADDR_W-1:0] rom_addr_t;
  typedef logic [FRAME_W-1:0] frame_t;
  typedef logic [3:0]        color_idx_t;

  // Animation frames sit back-to-back in ROM, each stored row-major.
  function automatic rom_addr_t pix_addr(input frame_t f, input logic [10:0] row,
                                         input logic [10:0] col);
    logic [31:0] a;
    a = 32'(f) * 32'(SPRITE_W * SPRITE_H) + 32'(row) * 32'(SPRITE_W) + 32'(col);
    return a[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/topgun_sprite_fetch_if.sv
// Raster, placement, sprite ROM and pixel-output signals of the sprite fetch stage.
// Streaming, one pixel per clock: no valid/ready, every cycle carries a pixel and nothing stalls.
interface topgun_sprite_fetch_if;
  import topgun_pkg::*;

  coord_t     DrawX;
  coord_t     DrawY;
  logic       blank;
  logic       frame_start;
  coord_t     sprite_x;
  coord_t     sprite_y;
  logic       sprite_en;
  logic       mirror;
  rom_addr_t  rom_addr;
  color_idx_t rom_data;
  color_idx_t pix_index;
  logic       pix_opaque;
  coord_t     DrawX_d;
  coord_t     DrawY_d;
  logic       blank_d;

  modport master (
    input  DrawX, DrawY, blank, frame_start,
    input  sprite_x, sprite_y, sprite_en, mirror,
    input  rom_data,
    output rom_addr, pix_index, pix_opaque, DrawX_d, DrawY_d, blank_d
  );

  modport slave (
    output DrawX, DrawY, blank, frame_start,
    output sprite_x, sprite_y, sprite_en, mirror,
    output rom_data,
    input  rom_addr, pix_index, pix_opaque, DrawX_d, DrawY_d, blank_d
  );

endinterface

// File: rtl/topgun_anim_ctr.sv
// Animation frame counter: steps the frame once every ANIM_DIV frame_start pulses.
module topgun_anim_ctr
  import topgun_pkg::*;
(
  input  logic   Clk,
  input  logic   Reset,
  input  logic   frame_start,
  output frame_t frame
);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt <= '0;
      frame   <= '0;
    end else if (frame_start) begin
      if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
        div_cnt <= '0;
        // With a single frame this compare is always true, so frame holds at 0.
        if (frame == FRAME_W'(NUM_FRAMES - 1)) frame <= '0;
        else                                   frame <= frame + FRAME_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/topgun_sprite_fetch.sv
// Sprite fetch stage: raster position -> sprite ROM address -> palette index + opaque flag.
// Fixed two-clock latency; raster sideband is delayed to stay aligned with the index.
module topgun_sprite_fetch
  import topgun_pkg::*;
(
  input logic                   Clk,
  input logic                   Reset,
  topgun_sprite_fetch_if.master bus
);

  coord_t sx, sy;
  logic   en, mir;
  frame_t frame;

  topgun_anim_ctr u_anim (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (bus.frame_start),
    .frame       (frame)
  );

  // Placement is sampled on frame_start; the pixel in that same cycle still sees the old values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sx  <= '0;
      sy  <= '0;
      en  <= 1'b0;
      mir <= 1'b0;
    end else if (bus.frame_start) begin
      sx  <= bus.sprite_x;
      sy  <= bus.sprite_y;
      en  <= bus.sprite_en;
      mir <= bus.mirror;
    end
  end

  // 11-bit compares so a sprite near the right/bottom edge clips rather than wraps.
  logic [10:0] x11, y11, sx11, sy11, dx, dy, col;
  logic        in_box;
  rom_addr_t   addr_next;

  always_comb begin
    x11       = {1'b0, bus.DrawX};
    y11       = {1'b0, bus.DrawY};
    sx11      = {1'b0, sx};
    sy11      = {1'b0, sy};
    dx        = x11 - sx11;
    dy        = y11 - sy11;
    col       = mir ? (11'(SPRITE_W - 1) - dx) : dx;
    in_box    = (x11 >= sx11) && (x11 < sx11 + 11'(SPRITE_W)) &&
                (y11 >= sy11) && (y11 < sy11 + 11'(SPRITE_H));
    addr_next = in_box ? pix_addr(frame, dy, col) : '0;
  end

  logic   hit_s1, blank_s1;
  coord_t x_s1, y_s1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.rom_addr <= '0;
      hit_s1       <= 1'b0;
      x_s1         <= '0;
      y_s1         <= '0;
      blank_s1     <= 1'b0;
    end else begin
      bus.rom_addr <= addr_next;
      hit_s1       <= in_box && en && bus.blank;
      x_s1         <= bus.DrawX;
      y_s1         <= bus.DrawY;
      blank_s1     <= bus.blank;
    end
  end

  // rom_data here answers the address registered one clock earlier.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.pix_index  <= '0;
      bus.pix_opaque <= 1'b0;
      bus.DrawX_d    <= '0;
      bus.DrawY_d    <= '0;
      bus.blank_d    <= 1'b0;
    end else begin
      bus.pix_index  <= bus.rom_data;
      bus.pix_opaque <= hit_s1 && (bus.rom_data != 4'(TRANSPARENT_IDX));
      bus.DrawX_d    <= x_s1;
      bus.DrawY_d    <= y_s1;
      bus.blank_d    <= blank_s1;
    end
  end

endmodule

// File: tb/tb_topgun_sprite_fetch.sv
// Directed bench for topgun_sprite_fetch with a combinational model of the sprite ROM data port.
module tb_topgun_sprite_fetch;
  import topgun_pkg::*;

  // clock / reset
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  topgun_sprite_fetch_if bus ();

  topgun_sprite_fetch dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  // ROM contents: low address nibble xor 0xA; force_en overrides the data word.
  logic       force_en;
  logic [3:0] force_val;

  function automatic logic [3:0] rom_fn(input rom_addr_t a);
    return a[3:0] ^ 4'hA;
  endfunction

  assign bus.rom_data = force_en ? force_val : rom_fn(bus.rom_addr);

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame_start pulse carrying new placement.
  task automatic latch(input coord_t x, input coord_t y, input logic e, input logic m);
    bus.sprite_x    = x;
    bus.sprite_y    = y;
    bus.sprite_en   = e;
    bus.mirror      = m;
    bus.frame_start = 1'b1;
    @(posedge Clk);
    #1;
    bus.frame_start = 1'b0;
  endtask

  // Present one pixel, then follow it through both pipeline stages.
  task automatic check_pix(input string tag, input coord_t x, input coord_t y, input logic b,
                           input rom_addr_t exp_addr, input logic exp_op);
    logic [3:0] exp_idx;
    exp_idx   = force_en ? force_val : rom_fn(exp_addr);
    bus.DrawX = x;
    bus.DrawY = y;
    bus.blank = b;
    @(posedge Clk);
    #1;
    chk({tag, ".rom_addr"}, 32'(bus.rom_addr), 32'(exp_addr));
    bus.blank = 1'b0;
    @(posedge Clk);
    #1;
    chk({tag, ".pix_opaque"}, 32'(bus.pix_opaque), 32'(exp_op));
    chk({tag, ".pix_index"},  32'(bus.pix_index),  32'(exp_idx));
    chk({tag, ".DrawX_d"},    32'(bus.DrawX_d),    32'(x));
    chk({tag, ".DrawY_d"},    32'(bus.DrawY_d),    32'(y));
    chk({tag, ".blank_d"},    32'(bus.blank_d),    32'(b));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rom_addr"},   32'(bus.rom_addr),   32'd0);
    chk({tag, ".pix_index"},  32'(bus.pix_index),  32'd0);
    chk({tag, ".pix_opaque"}, 32'(bus.pix_opaque), 32'd0);
    chk({tag, ".DrawX_d"},    32'(bus.DrawX_d),    32'd0);
    chk({tag, ".DrawY_d"},    32'(bus.DrawY_d),    32'd0);
    chk({tag, ".blank_d"},    32'(bus.blank_d),    32'd0);
  endtask

  initial begin
    Reset           = 1'b1;
    force_en        = 1'b0;
    force_val       = 4'd0;
    bus.DrawX       = '0;
    bus.DrawY       = '0;
    bus.blank       = 1'b0;
    bus.frame_start = 1'b0;
    bus.sprite_x    = '0;
    bus.sprite_y    = '0;
    bus.sprite_en   = 1'b0;
    bus.mirror      = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk_all_zero("reset");
    Reset = 1'b0;

    // 1. Opaque pixel streaming, then reset mid-line and refill.
    bus.DrawX = 10'd100;
    bus.DrawY = 10'd50;
    bus.blank = 1'b1;
    latch(10'd100, 10'd50, 1'b1, 1'b0);
    @(posedge Clk);
    #1;
    chk("fill.first_op", 32'(bus.pix_opaque), 32'd0);
    @(posedge Clk);
    #1;
    chk("fill.op", 32'(bus.pix_opaque), 32'd1);
    chk("fill.DrawX_d", 32'(bus.DrawX_d), 32'd100);
    #2;
    Reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    latch(10'd100, 10'd50, 1'b1, 1'b0);
    @(posedge Clk);
    #1;
    chk("refill.first_op", 32'(bus.pix_opaque), 32'd0);
    @(posedge Clk);
    #1;
    chk("refill.op", 32'(bus.pix_opaque), 32'd1);

    // 2. Left edge, no mirror (frame_start pulses since reset: 1).
    check_pix("left99",  10'd99,  10'd50, 1'b1, 13'd0, 1'b0);
    check_pix("left100", 10'd100, 10'd50, 1'b1, 13'd0, 1'b1);
    check_pix("left101", 10'd101, 10'd50, 1'b1, 13'd1, 1'b1);

    // 3. Mirrored (pulse 2).
    latch(10'd100, 10'd50, 1'b1, 1'b1);
    check_pix("mir100",    10'd100, 10'd50, 1'b1, 13'd63,   1'b1);
    check_pix("mir163",    10'd163, 10'd50, 1'b1, 13'd0,    1'b1);
    check_pix("mir164",    10'd164, 10'd50, 1'b1, 13'd0,    1'b0);
    check_pix("mir_row47", 10'd100, 10'd97, 1'b1, 13'd3071, 1'b1);
    check_pix("mir_row48", 10'd100, 10'd98, 1'b1, 13'd0,    1'b0);

    // 4. Right-edge clipping without wrap (pulses 3, 4).
    latch(10'd600, 10'd50, 1'b1, 1'b0);
    check_pix("clip639", 10'd639, 10'd50, 1'b1, 13'd39, 1'b1);
    latch(10'd620, 10'd50, 1'b1, 1'b0);
    check_pix("nowrap10", 10'd10, 10'd50, 1'b1, 13'd0, 1'b0);

    // 6. Transparency, blanking and disable (pulses 5, 6).
    latch(10'd100, 10'd50, 1'b1, 1'b0);
    force_en  = 1'b1;
    force_val = 4'(TRANSPARENT_IDX);
    check_pix("transp", 10'd101, 10'd50, 1'b1, 13'd1, 1'b0);
    force_en  = 1'b0;
    check_pix("blank0", 10'd101, 10'd50, 1'b0, 13'd1, 1'b0);
    latch(10'd100, 10'd50, 1'b0, 1'b0);
    check_pix("en0", 10'd101, 10'd50, 1'b1, 13'd1, 1'b0);

    // 5. Animation stepping from a clean reset.
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    repeat (7) latch(10'd200, 10'd100, 1'b1, 1'b0);
    check_pix("anim7", 10'd200, 10'd100, 1'b1, 13'd0, 1'b1);
    bus.DrawX = 10'd200;
    bus.DrawY = 10'd100;
    bus.blank = 1'b1;
    latch(10'd200, 10'd100, 1'b1, 1'b0);
    chk("anim8.same_cycle", 32'(bus.rom_addr), 32'd0);
    check_pix("anim8", 10'd200, 10'd100, 1'b1, 13'd3072, 1'b1);
    repeat (7) latch(10'd200, 10'd100, 1'b1, 1'b0);
    check_pix("anim15", 10'd200, 10'd100, 1'b1, 13'd3072, 1'b1);
    latch(10'd200, 10'd100, 1'b1, 1'b0);
    check_pix("anim16", 10'd200, 10'd100, 1'b1, 13'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
